// File: rtl/serial_mem_bridge_if.sv
// Signal bundle between serial_mem_bridge, its UART pair and the SRAM controller.
// master = the bridge (bus initiator, UART consumer); slave = the surrounding environment.
interface serial_mem_bridge_if;
  logic        rs232in_attention;
  logic [7:0]  rs232in_data;
  logic        rs232out_busy;
  logic        rs232out_w;
  logic [7:0]  rs232out_d;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  modport master (
    input  rs232in_attention, rs232in_data, rs232out_busy,
           mem_waitrequest, mem_readdata, mem_readdataid,
    output rs232out_w, rs232out_d, mem_id, mem_address, mem_read, mem_write,
           mem_writedata, mem_writedatamask
  );

  modport slave (
    output rs232in_attention, rs232in_data, rs232out_busy,
           mem_waitrequest, mem_readdata, mem_readdataid,
    input  rs232out_w, rs232out_d, mem_id, mem_address, mem_read, mem_write,
           mem_writedata, mem_writedatamask
  );
endinterface

// File: rtl/serial_mem_bridge.sv
// Serial command parser ('W' addr data / 'R' addr) driving an SRAM controller bus.
// Optional inter-byte gap timeout in ADDR/DATA: define SERIAL_MEM_BRIDGE_TIMEOUT_EN.
module serial_mem_bridge #(
  parameter logic [1:0]  ID      = 2'd3,
  parameter logic [31:0] TIMEOUT = 32'd4_000_000
) (
  input  logic                clock,
  input  logic                rst_n,
  serial_mem_bridge_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR_REQ, RD_REQ, RD_WAIT, TX} state_t;

  localparam logic [7:0] CMD_W     = 8'h57;
  localparam logic [7:0] CMD_R     = 8'h52;
  localparam logic [7:0] REPLY_OK  = 8'h2E;
  localparam logic [7:0] REPLY_ERR = 8'h3F;

  state_t      state_reg, state_next;
  logic [1:0]  index_reg, index_next;
  logic        is_write_reg, is_write_next;
  logic [29:0] addr_reg, addr_next;
  logic [23:0] data_reg, data_next;
  logic [31:0] tx_buf_reg, tx_buf_next;
  logic [1:0]  tx_last_reg, tx_last_next;
  logic        tx_done_reg, tx_done_next;
  logic        tx_pend_reg, tx_pend_next;
  logic        tx_guard_reg;
  logic        out_w_reg, out_w_next;
  logic [7:0]  out_d_reg, out_d_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic [29:0] mem_address_reg, mem_address_next;
  logic [31:0] mem_writedata_reg, mem_writedata_next;
  logic [3:0]  mem_mask_reg, mem_mask_next;
  logic [1:0]  mem_id_reg;
  logic        tx_free, tx_fire;

  // A byte may only be loaded once the previous strobe is gone; busy is not
  // trusted during the strobe or the cycle right after it.
  assign tx_free = !tx_pend_reg && !out_w_reg;
  assign tx_fire = tx_pend_reg && !bus.rs232out_busy && !out_w_reg && !tx_guard_reg;

`ifdef SERIAL_MEM_BRIDGE_TIMEOUT_EN
  logic [31:0] gap_reg, gap_next;
`else
  wire unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_next         = state_reg;
    index_next         = index_reg;
    is_write_next      = is_write_reg;
    addr_next          = addr_reg;
    data_next          = data_reg;
    tx_buf_next        = tx_buf_reg;
    tx_last_next       = tx_last_reg;
    tx_done_next       = tx_done_reg;
    tx_pend_next       = tx_pend_reg;
    out_w_next         = 1'b0;
    out_d_next         = out_d_reg;
    mem_read_next      = 1'b0;
    mem_write_next     = 1'b0;
    mem_address_next   = mem_address_reg;
    mem_writedata_next = mem_writedata_reg;
    mem_mask_next      = mem_mask_reg;

    if (tx_fire) begin
      out_w_next   = 1'b1;
      tx_pend_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (bus.rs232in_attention) begin
          index_next = 2'd0;
          if (bus.rs232in_data == CMD_W || bus.rs232in_data == CMD_R) begin
            is_write_next = (bus.rs232in_data == CMD_W);
            state_next    = ADDR;
          end else if (tx_free) begin
            out_d_next   = REPLY_ERR;
            tx_pend_next = 1'b1;
          end
        end
      end
      ADDR: begin
        if (bus.rs232in_attention) begin
          addr_next  = {addr_reg[21:0], bus.rs232in_data};
          index_next = index_reg + 2'd1;
          if (index_reg == 2'd3) begin
            if (is_write_reg) begin
              state_next = DATA;
            end else begin
              state_next       = RD_REQ;
              mem_read_next    = 1'b1;
              mem_address_next = {addr_reg[21:0], bus.rs232in_data};
            end
          end
        end
      end
      DATA: begin
        if (bus.rs232in_attention) begin
          data_next  = {data_reg[15:0], bus.rs232in_data};
          index_next = index_reg + 2'd1;
          if (index_reg == 2'd3) begin
            state_next         = WR_REQ;
            mem_write_next     = 1'b1;
            mem_mask_next      = 4'hF;
            mem_address_next   = addr_reg;
            mem_writedata_next = {data_reg, bus.rs232in_data};
          end
        end
      end
      WR_REQ: begin
        if (bus.mem_waitrequest) begin
          mem_write_next = 1'b1;
        end else begin
          state_next   = TX;
          tx_buf_next  = {REPLY_OK, 24'h0};
          tx_last_next = 2'd0;
          tx_done_next = 1'b0;
          index_next   = 2'd0;
        end
      end
      RD_REQ: begin
        if (bus.mem_waitrequest) mem_read_next = 1'b1;
        else                     state_next    = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_readdataid == ID) begin
          state_next   = TX;
          tx_buf_next  = bus.mem_readdata;
          tx_last_next = 2'd3;
          tx_done_next = 1'b0;
          index_next   = 2'd0;
        end
      end
      TX: begin
        // Leave only once the final strobe has completed.
        if (tx_free) begin
          if (tx_done_reg) begin
            state_next = IDLE;
            index_next = 2'd0;
          end else begin
            out_d_next   = tx_buf_reg[31:24];
            tx_buf_next  = {tx_buf_reg[23:0], 8'h00};
            tx_pend_next = 1'b1;
            index_next   = index_reg + 2'd1;
            if (index_reg == tx_last_reg) tx_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef SERIAL_MEM_BRIDGE_TIMEOUT_EN
    gap_next = 32'd0;
    if ((state_reg == ADDR || state_reg == DATA) && !bus.rs232in_attention) begin
      gap_next = gap_reg + 32'd1;
      if (gap_reg >= TIMEOUT - 32'd1) begin
        state_next = IDLE;
        index_next = 2'd0;
        gap_next   = 32'd0;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      index_reg         <= 2'd0;
      is_write_reg      <= 1'b0;
      addr_reg          <= '0;
      data_reg          <= '0;
      tx_buf_reg        <= '0;
      tx_last_reg       <= 2'd0;
      tx_done_reg       <= 1'b0;
      tx_pend_reg       <= 1'b0;
      tx_guard_reg      <= 1'b0;
      out_w_reg         <= 1'b0;
      out_d_reg         <= 8'h00;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
      mem_mask_reg      <= 4'h0;
      mem_id_reg        <= ID;
    end else begin
      state_reg         <= state_next;
      index_reg         <= index_next;
      is_write_reg      <= is_write_next;
      addr_reg          <= addr_next;
      data_reg          <= data_next;
      tx_buf_reg        <= tx_buf_next;
      tx_last_reg       <= tx_last_next;
      tx_done_reg       <= tx_done_next;
      tx_pend_reg       <= tx_pend_next;
      tx_guard_reg      <= out_w_reg;
      out_w_reg         <= out_w_next;
      out_d_reg         <= out_d_next;
      mem_read_reg      <= mem_read_next;
      mem_write_reg     <= mem_write_next;
      mem_address_reg   <= mem_address_next;
      mem_writedata_reg <= mem_writedata_next;
      mem_mask_reg      <= mem_mask_next;
      mem_id_reg        <= ID;
    end
  end

`ifdef SERIAL_MEM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) gap_reg <= 32'd0;
    else        gap_reg <= gap_next;
  end
`endif

  assign bus.rs232out_w        = out_w_reg;
  assign bus.rs232out_d        = out_d_reg;
  assign bus.mem_id            = mem_id_reg;
  assign bus.mem_address       = mem_address_reg;
  assign bus.mem_read          = mem_read_reg;
  assign bus.mem_write         = mem_write_reg;
  assign bus.mem_writedata     = mem_writedata_reg;
  assign bus.mem_writedatamask = mem_mask_reg;
endmodule

// File: doc/serial_mem_bridge.md
SERIAL_MEM_BRIDGE -- requirements
Module: serial_mem_bridge

Interface
REQ-001 SHALL have parameter ID, default 2'd3: mem_id driven on every request; readdata is accepted only when mem_readdataid equals ID.
REQ-002 SHALL have parameter TIMEOUT, default 32'd4_000_000: inter-byte gap limit, in clock cycles.
REQ-003 SHALL have port clock, input, 1: the single clock; all flops clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rs232in_attention, input, 1: one-cycle strobe marking rs232in_data valid.
REQ-006 SHALL have port rs232in_data, input, 8: received byte.
REQ-007 SHALL have port rs232out_busy, input, 1: transmitter busy.
REQ-008 SHALL have port rs232out_w, output, 1: one-cycle transmit strobe.
REQ-009 SHALL have port rs232out_d, output, 8: byte to transmit.
REQ-010 SHALL have ports mem_waitrequest (in, 1), mem_id (out, 2), mem_address (out, 30, word address), mem_read (out, 1), mem_write (out, 1), mem_writedata (out, 32), mem_writedatamask (out, 4), mem_readdata (in, 32), mem_readdataid (in, 2): the initiator side of the SRAM controller bus.

Function
REQ-011 SHALL parse commands of the form 0x57 'W' + 4 address bytes + 4 data bytes (write), and 0x52 'R' + 4 address bytes (read); all multi-byte fields are big-endian.
REQ-012 SHALL form mem_address from address bits [29:0]; the top 2 received bits are discarded.
REQ-013 SHALL use states IDLE, ADDR, DATA, WR_REQ, RD_REQ, RD_WAIT, TX; a 2-bit index counts bytes within ADDR, DATA and TX.
REQ-014 SHALL, in IDLE, transmit 0x3F '?' for any byte other than 'W' or 'R', and remain in IDLE.
REQ-015 SHALL, in WR_REQ, hold mem_write=1, mem_writedatamask=4'hF and stable address/data until a cycle with mem_waitrequest=0, then deassert mem_write the next cycle and transmit 0x2E '.'.
REQ-016 SHALL, in RD_REQ, hold mem_read=1 until a cycle with mem_waitrequest=0, then move to RD_WAIT.
REQ-017 SHALL, in RD_WAIT, capture mem_readdata on the first cycle with mem_readdataid==ID, ignore data carrying other ids, then transmit the 4 bytes MSB first.
REQ-018 SHALL drive mem_read and mem_write mutually exclusive, and never assert either outside WR_REQ or RD_REQ.
REQ-019 SHALL pulse rs232out_w only when rs232out_busy=0, hold rs232out_d stable during the pulse, and ignore busy on the cycle after a pulse.
REQ-020 SHALL discard, without a reply, bytes arriving in WR_REQ, RD_REQ, RD_WAIT or TX.
REQ-021 SHALL return to IDLE after the last TX byte; back-to-back commands need no idle gap.

Reset
REQ-022 SHALL, while rst_n=0, immediately force state=IDLE, index=0, rs232out_w=0, rs232out_d=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_writedatamask=0 and mem_id=ID, including in the middle of a bus request or a transmission.
REQ-023 SHALL resume in IDLE on the first clock edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with SERIAL_MEM_BRIDGE_TIMEOUT_EN defined, return silently from ADDR or DATA to IDLE when TIMEOUT cycles pass with no rs232in_attention; the gap counter restarts on each byte.
REQ-025 SHALL, without SERIAL_MEM_BRIDGE_TIMEOUT_EN, contain no timeout counter and wait in ADDR or DATA indefinitely.

Verification
REQ-026 SHALL cover: bytes 57 00 00 01 00 DE AD BE EF with waitrequest=1 for 3 cycles -> one write to address 0x100, data 0xDEADBEEF, mask F, mem_write high for 4 cycles, then '.' transmitted.
REQ-027 SHALL cover: bytes 52 C0 00 00 10 with readdata 0x12345678 returned with id 0 first and then with id 3 -> read of address 0x10, transmitted bytes 12 34 56 78.
REQ-028 SHALL cover: byte 0x41 -> 0x3F transmitted, no bus activity.
REQ-029 SHALL cover: rs232out_busy held high 10 cycles during a read reply -> no strobe while busy, all bytes in order.
REQ-030 SHALL cover: rst_n pulsed low during WR_REQ -> mem_write=0 within the same cycle; the next 'R' command then works.
REQ-031 SHALL cover, with the macro defined and TIMEOUT=100: 'W' followed by 2 bytes and a 150-cycle gap, then 52 00 00 00 00 -> a read of address 0 only, with no write issued.
